// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode constants and pointer/width helpers for the arbitrary-depth FIFO.
package fifo_pkg;
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Modulo-depth increment; depth need not be a power of two.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: modulo-DEPTH pointer register that advances when en is high.
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 13,
    parameter int PW    = clog2w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [PW-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= PW'(ptr_next(int'(ptr), DEPTH));
    end
endmodule

// File: rtl/sync_fifo_arb.sv
// sync_fifo_arb: single-clock FIFO of arbitrary depth with occupancy count, thresholds,
// sticky overflow/underflow flags and selectable standard or first-word-fall-through reads.
module sync_fifo_arb
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 13,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 11,
    parameter int AEMPTY_TH = 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = clog2w(DEPTH);

    if (DEPTH < 2 || AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 ||
        AEMPTY_TH > DEPTH - 1 || (FWFT != MODE_STD && FWFT != MODE_FWFT)) begin : g_bad_param
        $error("sync_fifo_arb: illegal parameter combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wr_acc, rd_acc;

    assign rd_acc       = rd_en & ~empty;
    assign wr_acc       = wr_en & (~full | rd_acc);
    assign full         = count == CNT_W'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CNT_W'(AFULL_TH);
    assign almost_empty = count <= CNT_W'(AEMPTY_TH);

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk(clk), .rst(rst), .en(wr_acc), .ptr(wr_ptr)
    );
    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk(clk), .rst(rst), .en(rd_acc), .ptr(rd_ptr)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            overflow  <= (wr_en & ~wr_acc) | (overflow & ~err_clr);
            underflow <= (rd_en & ~rd_acc) | (underflow & ~err_clr);
        end
    end

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign dout       = mem[rd_ptr];
        assign dout_valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= rd_acc;
                if (rd_acc)
                    dout <= mem[rd_ptr];
            end
        end
    end
endmodule
